tt_eval_seq: RTL and testbench



---
 rtl/tt_eval_seq.sv | 121 ++++++++++++
 tb/tb_tt_eval_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt_eval_seq.sv
// Run-time loadable N-input truth-table gate: serial shadow load with atomic commit,
// a registered lookup, and a settle filter that models gate response delay on the output.
module tt_eval_seq #(
    parameter int                       NUM_IN     = 3,
    parameter logic [(2**NUM_IN)-1:0]   TT_DEFAULT = 8'hEF,
    parameter int                       SETTLE     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IN-1:0] in_bus,
    input  logic              in_valid,
    input  logic              cfg_start,
    input  logic              cfg_bit,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              cfg_done,
    output logic              out,
    output logic              out_change,
    output logic              busy
);
    localparam int TT_W = 2**NUM_IN;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOAD = 1'b1;
    localparam logic [NUM_IN:0] LAST_IDX = (NUM_IN+1)'(TT_W-1);
    localparam logic [3:0]      SETTLE_W = 4'(SETTLE);

    logic [0:0]        r_state;
    logic [NUM_IN:0]   r_ld_cnt;
    logic [TT_W-1:0]   r_shadow;
    logic [TT_W-1:0]   r_tt;
    logic              r_cfg_done;

    logic [1:0]        r_vld_pipe;   // [0]: index captured, [1]: raw lookup valid
    logic [NUM_IN-1:0] r_idx;
    logic              r_raw;
    logic [3:0]        r_cnt;
    logic              r_out;
    logic              r_out_change;

    logic              w_accept;
    logic              w_commit;
    logic [TT_W-1:0]   w_shadow_nxt;
    logic [3:0]        w_cnt_inc;

    assign w_accept  = (r_state == S_LOAD) && cfg_valid && !cfg_start;
    assign w_commit  = w_accept && (r_ld_cnt == LAST_IDX);
    assign w_cnt_inc = r_cnt + 4'd1;

    // Committed table must include the bit accepted on the commit edge itself.
    always_comb begin
        w_shadow_nxt = r_shadow;
        w_shadow_nxt[r_ld_cnt[NUM_IN-1:0]] = cfg_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ld_cnt   <= '0;
            r_shadow   <= '0;
            r_tt       <= TT_DEFAULT;
            r_cfg_done <= 1'b0;
        end else begin
            r_cfg_done <= 1'b0;
            if (cfg_start) begin
                r_state  <= S_LOAD;
                r_ld_cnt <= '0;
                r_shadow <= '0;
            end else if (w_accept) begin
                r_shadow <= w_shadow_nxt;
                r_ld_cnt <= r_ld_cnt + 1'b1;
                if (w_commit) begin
                    r_tt       <= w_shadow_nxt;
                    r_state    <= S_IDLE;
                    r_cfg_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_idx      <= '0;
            r_raw      <= 1'b0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], in_valid};
            if (in_valid) r_idx <= in_bus;
            r_raw <= r_tt[r_idx];
        end
    end

    // Invalid gaps leave the count alone; only a valid matching sample clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_out        <= TT_DEFAULT[0];
            r_out_change <= 1'b0;
        end else begin
            r_out_change <= 1'b0;
            if (r_vld_pipe[1]) begin
                if (r_raw != r_out) begin
                    if (w_cnt_inc == SETTLE_W) begin
                        r_out        <= r_raw;
                        r_cnt        <= '0;
                        r_out_change <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end
    end

    assign cfg_ready  = (r_state == S_LOAD);
    assign busy       = (r_state == S_LOAD);
    assign cfg_done   = r_cfg_done;
    assign out        = r_out;
    assign out_change = r_out_change;
endmodule

// File: tb/tb_tt_eval_seq.sv
// Directed bench for tt_eval_seq with default parameters (3 inputs, table 8'hEF, settle 4).
module tb_tt_eval_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in_bus;
    logic       in_valid;
    logic       cfg_start;
    logic       cfg_bit;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_done;
    logic       out;
    logic       out_change;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_oc    = 0;
    int n_done  = 0;
    int oc0, dn0;

    tt_eval_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_bus     (in_bus),
        .in_valid   (in_valid),
        .cfg_start  (cfg_start),
        .cfg_bit    (cfg_bit),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_done   (cfg_done),
        .out        (out),
        .out_change (out_change),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_change) n_oc++;
        if (cfg_done)   n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_bus = '0;
        cfg_start = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0;
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic drive(input logic v, input logic [2:0] b, input int n);
        in_valid = v;
        in_bus   = b;
        repeat (n) tick;
    endtask

    // Hold idx long enough to settle and drain, then out must equal the table entry.
    task automatic probe(input string tag, input logic [2:0] idx, input logic exp);
        drive(1'b1, idx, 4);
        drive(1'b0, idx, 3);
        chk(tag, 32'(out), 32'(exp));
    endtask

    task automatic load(input logic [7:0] v, input int nbits, input bit toggle);
        logic [7:0] val;
        val = v;
        cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
        chk("load_ready", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            if (toggle && (i % 2 == 1)) begin
                cfg_valid = 1'b0;
                tick;
            end
            cfg_valid = 1'b1;
            cfg_bit   = val[i];
            tick;
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        do_reset;
        // reset state
        chk("rst_out", 32'(out), 32'd1);
        chk("rst_oc", 32'(out_change), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_done", 32'(cfg_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // 1: every index except 4 (the only zero entry of 8'hEF) keeps out high
        oc0 = n_oc;
        for (int i = 0; i < 8; i++)
            if (i != 4) drive(1'b1, 3'(i), 2);
        drive(1'b0, 3'd0, 3);
        chk("t1_others_out", 32'(out), 32'd1);
        chk("t1_others_oc", 32'(n_oc - oc0), 32'd0);
        drive(1'b1, 3'd4, 4);
        drive(1'b0, 3'd4, 1);
        chk("t1_k4_out", 32'(out), 32'd1);
        tick;
        chk("t1_k5_out", 32'(out), 32'd0);
        chk("t1_k5_oc", 32'(out_change), 32'd1);
        tick;
        chk("t1_k6_oc", 32'(out_change), 32'd0);
        chk("t1_oc_cnt", 32'(n_oc - oc0), 32'd1);

        // 2: glitch rejection, count cleared by a matching sample
        do_reset;
        oc0 = n_oc;
        drive(1'b1, 3'd4, 3);
        drive(1'b1, 3'd0, 1);
        drive(1'b1, 3'd4, 3);
        drive(1'b0, 3'd0, 4);
        chk("t2_out", 32'(out), 32'd1);
        chk("t2_oc_cnt", 32'(n_oc - oc0), 32'd0);

        // 3: invalid gap holds the count
        do_reset;
        drive(1'b1, 3'd4, 1);
        drive(1'b0, 3'd4, 2);
        drive(1'b1, 3'd4, 3);
        drive(1'b0, 3'd4, 1);
        chk("t3_k6_out", 32'(out), 32'd1);
        tick;
        chk("t3_k7_out", 32'(out), 32'd0);

        // 4: load AND3 with gapped cfg_valid
        do_reset;
        dn0 = n_done;
        load(8'h80, 8, 1'b1);
        chk("t4_done", 32'(cfg_done), 32'd1);
        chk("t4_idle_ready", 32'(cfg_ready), 32'd0);
        chk("t4_idle_busy", 32'(busy), 32'd0);
        tick;
        chk("t4_done_clr", 32'(cfg_done), 32'd0);
        chk("t4_done_cnt", 32'(n_done - dn0), 32'd1);
        probe("t4_and_111", 3'd7, 1'b1);
        probe("t4_and_110", 3'd6, 1'b0);
        probe("t4_and_111b", 3'd7, 1'b1);

        // 5: restart mid-load; old table stays live during the load
        do_reset;
        dn0 = n_done;
        load(8'hFF, 5, 1'b0);
        probe("t5_old_tbl", 3'd4, 1'b0);
        chk("t5_busy", 32'(busy), 32'd1);
        load(8'h01, 8, 1'b0);
        tick;
        chk("t5_done_cnt", 32'(n_done - dn0), 32'd1);
        probe("t5_idx1", 3'd1, 1'b0);
        probe("t5_idx0", 3'd0, 1'b1);
        probe("t5_idx5", 3'd5, 1'b0);
        probe("t5_idx4", 3'd4, 1'b0);

        // 5b: reset during a load restores the default table
        load(8'h00, 3, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(cfg_ready), 32'd0);
        chk("t5_rst_out", 32'(out), 32'd1);
        tick;
        rst_n = 1'b1;
        tick;
        probe("t5_rst_idx1", 3'd1, 1'b1);
        probe("t5_rst_idx4", 3'd4, 1'b0);

        // cfg_valid in IDLE is ignored
        dn0 = n_done;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b0;
        repeat (10) tick;
        cfg_valid = 1'b0;
        chk("idle_ready", 32'(cfg_ready), 32'd0);
        chk("idle_done_cnt", 32'(n_done - dn0), 32'd0);
        probe("idle_tbl", 3'd0, 1'b1);

        // cfg_start with the final bit: restart wins, no commit
        do_reset;
        dn0 = n_done;
        load(8'h00, 7, 1'b0);
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b0;
        tick;
        cfg_start = 1'b0; cfg_valid = 1'b0;
        chk("coin_ready", 32'(cfg_ready), 32'd1);
        tick;
        chk("coin_done_cnt", 32'(n_done - dn0), 32'd0);
        probe("coin_tbl", 3'd0, 1'b1);

        // 6: commit while index 0 streams; lookup sees the new table one edge later
        do_reset;
        in_valid = 1'b1;
        in_bus   = 3'd0;
        load(8'hFE, 8, 1'b0);
        repeat (4) tick;
        chk("t6_c4_out", 32'(out), 32'd1);
        tick;
        chk("t6_c5_out", 32'(out), 32'd0);
        chk("t6_c5_oc", 32'(out_change), 32'd1);
        in_valid = 1'b0;
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
